// File: rtl/hyperbus_arb_pkg.sv
// Shared state encodings, index types and helpers for the HyperBus transaction arbiter.
package hyperbus_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StIssue = 2'd1;
    localparam state_t StBusy  = 2'd2;
    localparam state_t StGap   = 2'd3;

    // Upper bound on chip selects decodable by onehot(); instances slice down to NumCs.
    localparam int unsigned MaxCs = 32;

    typedef logic [4:0] cs_idx_t;
    typedef logic [7:0] owner_t;

    function automatic logic [MaxCs-1:0] onehot(input cs_idx_t idx);
        logic [MaxCs-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hyperbus_rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i at or after ptr_i, wrapping.
module hyperbus_rr_pick #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = 1
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              found_o
);

    int unsigned cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = (32'(ptr_i) + k) % NumReq;
            if (!found_o && valid_i[cand[IdxW-1:0]]) begin
                idx_o   = cand[IdxW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hyperbus_txn_arbiter.sv
// Round-robin arbiter sharing one HyperBus PHY command port, with CS decode,
// enforced CS-high gap between transactions and a watchdog that aborts hung bursts.
module hyperbus_txn_arbiter
    import hyperbus_arb_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned NumCs         = 2,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned LenWidth      = 8,
    parameter int unsigned CsAddrLsb     = 24,
    parameter int unsigned CsGapCycles   = 4,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned OwnerW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                           clk_sys_i,
    input  logic                           rst_i,
    input  logic [NumReq-1:0]              req_valid_i,
    output logic [NumReq-1:0]              req_ready_o,
    input  logic [NumReq-1:0]              req_write_i,
    input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq*LenWidth-1:0]     req_len_i,
    output logic [NumReq-1:0]              done_o,
    output logic [NumReq-1:0]              err_o,
    output logic                           phy_valid_o,
    input  logic                           phy_ready_i,
    output logic                           phy_write_o,
    output logic [AddrWidth-1:0]           phy_addr_o,
    output logic [LenWidth-1:0]            phy_len_o,
    output logic [NumCs-1:0]               phy_cs_o,
    input  logic                           phy_done_i,
    output logic                           phy_abort_o,
    output logic                           busy_o,
    output logic [OwnerW-1:0]              owner_o
);

    localparam int unsigned CsW    = (NumCs > 1) ? $clog2(NumCs) : 1;
    localparam int unsigned TimerW = $clog2(TimeoutCycles) + 1;
    localparam int unsigned GapW   = (CsGapCycles > 1) ? $clog2(CsGapCycles) : 1;

    state_t              state_q, state_d;
    logic [OwnerW-1:0]   ptr_q, ptr_next;
    logic [OwnerW-1:0]   owner_q;
    logic [OwnerW-1:0]   pick_idx;
    logic                pick_found;
    logic [TimerW-1:0]   timer_q;
    logic [GapW-1:0]     gap_q;
    logic                gap_last;
    logic                done_hit;
    logic                timeout_hit;

    logic                sel_write;
    logic [AddrWidth-1:0] sel_addr;
    logic [LenWidth-1:0] sel_len;
    logic [NumCs-1:0]    sel_cs;

    logic                phy_write_q;
    logic [AddrWidth-1:0] phy_addr_q;
    logic [LenWidth-1:0] phy_len_q;
    logic [NumCs-1:0]    phy_cs_q;

    hyperbus_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (OwnerW)
    ) u_rr_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (pick_idx == OwnerW'(i)) begin
                sel_write = req_write_i[i];
                sel_addr  = req_addr_i[i*AddrWidth +: AddrWidth];
                sel_len   = req_len_i[i*LenWidth +: LenWidth];
            end
        end
    end

    if (NumCs > 1) begin : g_cs_decode
        logic [MaxCs-1:0] cs_full;
        assign cs_full = onehot(cs_idx_t'(sel_addr[CsAddrLsb +: CsW]));
        assign sel_cs  = cs_full[NumCs-1:0];
    end else begin : g_cs_single
        assign sel_cs = 1'b1;
    end

    assign ptr_next = (pick_idx == OwnerW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;

    // Completion beats the watchdog when both land in the same cycle.
    assign done_hit    = (state_q == StBusy) && phy_done_i;
    assign timeout_hit = (state_q == StBusy) && !phy_done_i &&
                         (timer_q == TimerW'(TimeoutCycles - 1));
    assign gap_last    = (CsGapCycles == 0) || (gap_q == GapW'(CsGapCycles - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_found) state_d = StIssue;
            StIssue: if (phy_ready_i) state_d = StBusy;
            StBusy: begin
                if (done_hit || timeout_hit) begin
                    state_d = (CsGapCycles == 0) ? StIdle : StGap;
                end
            end
            StGap:   if (gap_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            phy_write_q <= 1'b0;
            phy_addr_q  <= '0;
            phy_len_q   <= '0;
            phy_cs_q    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        phy_write_q <= sel_write;
                        phy_addr_q  <= sel_addr;
                        phy_len_q   <= sel_len;
                        phy_cs_q    <= sel_cs;
                        owner_q     <= pick_idx;
                        ptr_q       <= ptr_next;
                    end
                end
                StIssue: begin
                    if (phy_ready_i) timer_q <= '0;
                end
                StBusy: begin
                    if (timer_q != {TimerW{1'b1}}) timer_q <= timer_q + 1'b1;
                    if (done_hit || timeout_hit) gap_q <= '0;
                end
                StGap: begin
                    gap_q <= gap_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reset gating keeps the combinational grant quiet while rst_i is held.
    always_comb begin
        req_ready_o = '0;
        done_o      = '0;
        err_o       = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            req_ready_o[i] = !rst_i && (state_q == StIdle) && pick_found &&
                             (pick_idx == OwnerW'(i));
            done_o[i]      = done_hit && (owner_q == OwnerW'(i));
            err_o[i]       = timeout_hit && (owner_q == OwnerW'(i));
        end
    end

    assign phy_valid_o = (state_q == StIssue);
    assign phy_abort_o = timeout_hit;
    assign busy_o      = (state_q != StIdle);
    assign owner_o     = owner_q;
    assign phy_write_o = phy_write_q;
    assign phy_addr_o  = phy_addr_q;
    assign phy_len_o   = phy_len_q;
    assign phy_cs_o    = phy_cs_q;

endmodule

// File: tb/tb_hyperbus_txn_arbiter.sv
// Directed bench with a transaction-level reference model checked every cycle.
module tb_hyperbus_txn_arbiter;

    localparam int NR  = 2;
    localparam int NCS = 2;
    localparam int AW  = 32;
    localparam int LW  = 8;
    localparam int CSL = 24;
    localparam int GAP = 4;
    localparam int TO  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_write = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*LW-1:0] req_len = '0;
    logic [NR-1:0]    done;
    logic [NR-1:0]    err;
    logic             phy_valid;
    logic             phy_ready = 1'b0;
    logic             phy_write;
    logic [AW-1:0]    phy_addr;
    logic [LW-1:0]    phy_len;
    logic [NCS-1:0]   phy_cs;
    logic             phy_done = 1'b0;
    logic             phy_abort;
    logic             busy;
    logic [0:0]       owner;

    int n_vec = 0;
    int n_err = 0;

    hyperbus_txn_arbiter #(
        .NumReq        (NR),
        .NumCs         (NCS),
        .AddrWidth     (AW),
        .LenWidth      (LW),
        .CsAddrLsb     (CSL),
        .CsGapCycles   (GAP),
        .TimeoutCycles (TO)
    ) dut (
        .clk_sys_i   (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .done_o      (done),
        .err_o       (err),
        .phy_valid_o (phy_valid),
        .phy_ready_i (phy_ready),
        .phy_write_o (phy_write),
        .phy_addr_o  (phy_addr),
        .phy_len_o   (phy_len),
        .phy_cs_o    (phy_cs),
        .phy_done_i  (phy_done),
        .phy_abort_o (phy_abort),
        .busy_o      (busy),
        .owner_o     (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int            m_ptr, m_owner, m_age, m_gap, m_win;
    logic          m_pending, m_inflight, m_idle;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    logic [NCS-1:0] m_cs;
    logic [NR-1:0] e_ready, e_done, e_err;
    logic          e_timeout;

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    assign m_idle    = !m_pending && !m_inflight && (m_gap == 0);
    assign m_win     = pick(req_valid, m_ptr);
    assign e_ready   = (m_idle && m_win >= 0 && !rst) ? NR'(1 << m_win) : '0;
    assign e_timeout = m_inflight && !phy_done && (m_age == TO - 1);
    assign e_done    = (m_inflight && phy_done) ? NR'(1 << m_owner) : '0;
    assign e_err     = e_timeout ? NR'(1 << m_owner) : '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr <= 0; m_owner <= 0; m_age <= 0; m_gap <= 0;
            m_pending <= 1'b0; m_inflight <= 1'b0;
            m_write <= 1'b0; m_addr <= '0; m_len <= '0; m_cs <= '0;
        end else if (m_idle && m_win >= 0) begin
            m_owner   <= m_win;
            m_ptr     <= (m_win + 1) % NR;
            m_pending <= 1'b1;
            m_write   <= req_write[m_win];
            m_addr    <= req_addr[m_win*AW +: AW];
            m_len     <= req_len[m_win*LW +: LW];
            m_cs      <= NCS'(1 << ((req_addr[m_win*AW +: AW] >> CSL) % NCS));
        end else if (m_pending) begin
            if (phy_ready) begin
                m_pending  <= 1'b0;
                m_inflight <= 1'b1;
                m_age      <= 0;
            end
        end else if (m_inflight) begin
            if (phy_done || m_age == TO - 1) begin
                m_inflight <= 1'b0;
                m_gap      <= GAP;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m_gap > 0) begin
            m_gap <= m_gap - 1;
        end
    end

    always @(negedge clk) begin
        check("req_ready", req_ready, e_ready);
        check("phy_valid", phy_valid, m_pending);
        check("busy", busy, !m_idle);
        check("done", done, e_done);
        check("err", err, e_err);
        check("phy_abort", phy_abort, e_timeout);
        check("phy_write", phy_write, m_write);
        check("phy_addr", phy_addr, m_addr);
        check("phy_len", phy_len, m_len);
        check("phy_cs", phy_cs, m_cs);
        check("owner", owner, m_owner[0]);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int who);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 30) begin
            cyc();
            @(negedge clk);
            n++;
        end
        check("grant_seen", (req_ready != '0), 1);
        who = req_ready[1] ? 1 : (req_ready[0] ? 0 : -1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            cyc();
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
        cyc();
    endtask

    initial begin
        int who;
        int k;

        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", phy_valid, 0);
        check("rst_cs", phy_cs, 0);
        cyc();
        rst = 1'b0;

        // 1: single write from requester 0
        req_valid = 2'b01; req_write = 2'b01; req_len[7:0] = 8'd3;
        req_addr[31:0] = 32'h0100_0040;
        @(negedge clk);
        check("t1_ready", req_ready, 2'b01);
        cyc();
        req_valid = '0; phy_ready = 1'b1;
        @(negedge clk);
        check("t1_valid", phy_valid, 1);
        check("t1_cs", phy_cs, 2'b10);
        check("t1_len", phy_len, 3);
        check("t1_addr", phy_addr, 32'h0100_0040);
        cyc();
        phy_ready = 1'b0;
        repeat (9) cyc();
        phy_done = 1'b1;
        @(negedge clk);
        check("t1_done", done, 2'b01);
        cyc();
        phy_done = 1'b0;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            check("t1_gap_busy", busy, 1);
            cyc();
        end
        @(negedge clk);
        check("t1_gap_end", busy, 0);
        cyc();

        // 2: both requesters held valid from reset; grants must alternate
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_valid = 2'b11;
        req_addr = {32'h0100_1000, 32'h0000_0000};
        req_len = {8'd5, 8'd1};
        req_write = 2'b10;
        for (int t = 0; t < 4; t++) begin
            wait_grant(who);
            check("t2_grant", who, t % 2);
            cyc();
            phy_ready = 1'b1;
            cyc();
            phy_ready = 1'b0; phy_done = 1'b1;
            cyc();
            phy_done = 1'b0;
            if (t == 3) req_valid = '0;
        end
        wait_idle();

        // 3: PHY stalls for 7 cycles
        req_valid = 2'b01; req_write = 2'b00;
        req_addr[31:0] = 32'h0000_0200; req_len[7:0] = 8'd7;
        wait_grant(who);
        cyc();
        req_valid = '0;
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            check("t3_hold_valid", phy_valid, 1);
            check("t3_hold_addr", phy_addr, 32'h0000_0200);
            check("t3_hold_len", phy_len, 7);
            cyc();
        end
        phy_ready = 1'b1;
        @(negedge clk);
        check("t3_accept_valid", phy_valid, 1);
        cyc();
        phy_ready = 1'b0;
        @(negedge clk);
        check("t3_after_valid", phy_valid, 0);
        phy_done = 1'b1;
        cyc();
        phy_done = 1'b0;
        wait_idle();

        // 4: watchdog timeout on requester 1
        req_valid = 2'b10; req_write = 2'b10;
        req_addr[63:32] = 32'h0100_0000; req_len[15:8] = 8'h20;
        wait_grant(who);
        check("t4_grant", who, 1);
        cyc();
        req_valid = '0; phy_ready = 1'b1;
        cyc();
        phy_ready = 1'b0;
        k = 1;
        @(negedge clk);
        while (!phy_abort && k < 40) begin
            cyc();
            @(negedge clk);
            k++;
        end
        check("t4_abort_cycle", k, 16);
        check("t4_err", err, 2'b10);
        cyc();
        @(negedge clk);
        check("t4_gap_busy", busy, 1);
        check("t4_abort_once", phy_abort, 0);
        cyc();
        wait_idle();

        // 5: done coincides with the timeout cycle; done outside BUSY ignored
        req_valid = 2'b01; req_addr[31:0] = 32'h0000_0000;
        wait_grant(who);
        cyc();
        req_valid = '0; phy_ready = 1'b1;
        cyc();
        phy_ready = 1'b0;
        repeat (15) cyc();
        phy_done = 1'b1;
        @(negedge clk);
        check("t5_done", done, 2'b01);
        check("t5_err", err, 2'b00);
        check("t5_abort", phy_abort, 0);
        cyc();
        @(negedge clk);
        check("t5_stray_done", done, 2'b00);
        cyc();
        phy_done = 1'b0;
        wait_idle();

        // 6: reset while BUSY, pointer must return to 0
        req_valid = 2'b01;
        wait_grant(who);
        cyc();
        req_valid = '0; phy_ready = 1'b1;
        cyc();
        phy_ready = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_owner", owner, 0);
        check("t6_addr", phy_addr, 0);
        check("t6_cs", phy_cs, 0);
        check("t6_write", phy_write, 0);
        check("t6_abort", phy_abort, 0);
        req_valid = 2'b11;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t6_ptr_reset", req_ready, 2'b01);
        #1;
        req_valid = 2'b10;
        cyc();
        @(negedge clk);
        check("t6_owner1", owner, 1);
        check("t6_valid", phy_valid, 1);
        check("t6_cs1", phy_cs, 2'b10);
        #1;
        req_valid = '0; phy_ready = 1'b1;
        cyc();
        phy_ready = 1'b0; phy_done = 1'b1;
        cyc();
        phy_done = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
